// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the parametrised UART transmitter:
//     - state_t      : 3-bit FSM state encoding
//     - PAR_*        : parity-mode encodings on i_Parity_Mode
//     - calc_parity  : parity bit for a (zero-extended) data word
//   Build option: UART_TX_PARITY_EN adds the PARITY state to the encoding.
// -----------------------------------------------------------------------------
package uart_pkg;

  // Widest data word the transmitter supports; narrower words are
  // zero-extended to this width before the parity reduction.
  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  // Mode 2'b11 is treated the same as PAR_NONE.
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Even parity = XOR of the data bits; odd parity is its complement.
  // Zero-extension does not change the XOR reduction.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                       input logic [1:0]               mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
//   Bit-time counter. Counts 0..CLKS_PER_BIT-1 and wraps; o_Tick marks the last
//   cycle of each bit period. i_Clear holds the count at zero.
// Ports:
//   i_Clock  in  system clock, rising edge
//   i_Rst_n  in  asynchronous active-low reset
//   i_Clear  in  synchronous clear of the bit-time counter
//   o_Tick   out high while count == CLKS_PER_BIT-1
// -----------------------------------------------------------------------------
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic i_Clock,
  input  logic i_Rst_n,
  input  logic i_Clear,
  output logic o_Tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_count;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values of its inputs.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_count <= '0;
    end else if (i_Clear || o_Tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_Tick = (r_count == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
//   Parametrised UART serial transmitter: start bit, DATA_BITS data bits LSB
//   first, optional parity bit, STOP_BITS stop bits. Valid/ready handshake;
//   a held i_TX_DV is accepted in the IDLE cycle where o_TX_Done pulses, so
//   back-to-back frames are separated by exactly one mark cycle.
// Build option:
//   UART_TX_PARITY_EN  defined   : PARITY state built, i_Parity_Mode 01/10
//                                  inserts an even/odd parity bit.
//                      undefined : no parity logic, i_Parity_Mode ignored.
// Parameters:
//   CLKS_PER_BIT (>=2), DATA_BITS (5..9), STOP_BITS (1..2)
// Ports:
//   i_Clock        in   system clock, rising edge
//   i_Rst_n        in   asynchronous active-low reset
//   i_TX_DV        in   byte valid
//   i_TX_Byte      in   data to send, captured on accept
//   i_Parity_Mode  in   00 none, 01 even, 10 odd, 11 none; captured on accept
//   o_TX_Ready     out  high in IDLE
//   o_TX_Active    out  high from the accept edge until the frame ends
//   o_TX_Serial    out  serial line, idle/mark = 1
//   o_TX_Done      out  one-cycle pulse when the frame completes
// -----------------------------------------------------------------------------
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_TX_DV,
  input  logic [DATA_BITS-1:0] i_TX_Byte,
  input  logic [1:0]           i_Parity_Mode,
  output logic                 o_TX_Ready,
  output logic                 o_TX_Active,
  output logic                 o_TX_Serial,
  output logic                 o_TX_Done
);

  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
    $error("uart_tx_frame: illegal CLKS_PER_BIT/DATA_BITS/STOP_BITS");
  end

  localparam int IDXW = $clog2(DATA_BITS);
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(DATA_BITS - 1);
  localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

  state_t               r_state, w_state_next;
  logic [DATA_BITS-1:0] r_data;
  logic [IDXW-1:0]      r_bit_idx, w_bit_idx_next;
  logic                 r_stop_cnt, w_stop_cnt_next;
  logic                 r_serial, w_serial_next;
  logic                 r_active, w_active_next;
  logic                 r_done, w_done_next;
  logic                 w_accept;
  logic                 w_tick;

  assign w_accept = i_TX_DV && (r_state == ST_IDLE);

  // Counter is held clear throughout IDLE, so every frame starts with a full
  // bit period for the start bit.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .i_Clock(i_Clock),
    .i_Rst_n(i_Rst_n),
    .i_Clear(r_state == ST_IDLE),
    .o_Tick (w_tick)
  );

`ifdef UART_TX_PARITY_EN
  logic [1:0] r_par_mode;
  logic       w_par_en;
  logic       w_par_bit;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_par_mode <= PAR_NONE;
    end else if (w_accept) begin
      r_par_mode <= i_Parity_Mode;
    end
  end

  assign w_par_en  = (r_par_mode == PAR_EVEN) || (r_par_mode == PAR_ODD);
  assign w_par_bit = calc_parity(MAX_DATA_BITS'(r_data), r_par_mode);
`else
  // Parity mode has no function in this build; the port stays for a
  // uniform interface.
  logic w_unused_par_mode;
  assign w_unused_par_mode = ^i_Parity_Mode;
`endif

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state    <= ST_IDLE;
      r_data     <= '0;
      r_bit_idx  <= '0;
      r_stop_cnt <= 1'b0;
      r_serial   <= 1'b1;
      r_active   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_bit_idx  <= w_bit_idx_next;
      r_stop_cnt <= w_stop_cnt_next;
      r_serial   <= w_serial_next;
      r_active   <= w_active_next;
      r_done     <= w_done_next;
      if (w_accept) begin
        r_data <= i_TX_Byte;
      end
    end
  end

  // Next-state and registered-output logic. The serial value is computed one
  // cycle ahead so that the line changes exactly on the bit boundary edge.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves a
    // value unassigned and no latch is inferred.
    w_state_next    = r_state;
    w_bit_idx_next  = r_bit_idx;
    w_stop_cnt_next = r_stop_cnt;
    w_serial_next   = r_serial;
    w_active_next   = r_active;
    w_done_next     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_serial_next = 1'b1;
        if (w_accept) begin
          w_state_next    = ST_START;
          w_serial_next   = 1'b0;
          w_active_next   = 1'b1;
          w_bit_idx_next  = '0;
          w_stop_cnt_next = 1'b0;
        end
      end

      ST_START: begin
        if (w_tick) begin
          w_state_next   = ST_DATA;
          w_bit_idx_next = '0;
          w_serial_next  = r_data[0];
        end
      end

      ST_DATA: begin
        if (w_tick) begin
          if (r_bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            if (w_par_en) begin
              w_state_next  = ST_PARITY;
              w_serial_next = w_par_bit;
            end else begin
              w_state_next    = ST_STOP;
              w_serial_next   = 1'b1;
              w_stop_cnt_next = 1'b0;
            end
`else
            w_state_next    = ST_STOP;
            w_serial_next   = 1'b1;
            w_stop_cnt_next = 1'b0;
`endif
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
            w_serial_next  = r_data[w_bit_idx_next];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_tick) begin
          w_state_next    = ST_STOP;
          w_serial_next   = 1'b1;
          w_stop_cnt_next = 1'b0;
        end
      end
`endif

      ST_STOP: begin
        w_serial_next = 1'b1;
        if (w_tick) begin
          if (r_stop_cnt == STOP_LAST) begin
            w_state_next  = ST_IDLE;
            w_active_next = 1'b0;
            w_done_next   = 1'b1;
          end else begin
            w_stop_cnt_next = r_stop_cnt + 1'b1;
          end
        end
      end

      default: begin
        w_state_next  = ST_IDLE;
        w_serial_next = 1'b1;
        w_active_next = 1'b0;
      end
    endcase
  end

  assign o_TX_Ready  = (r_state == ST_IDLE);
  assign o_TX_Active = r_active;
  assign o_TX_Serial = r_serial;
  assign o_TX_Done   = r_done;

endmodule

// File: tb/tb_uart_tx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame
//   Three transmitters at CLKS_PER_BIT=4: index 0 is 8N1, index 1 has 7 data
//   bits and one stop bit, index 2 has 8 data bits and two stop bits. Each
//   accepted byte pushes its expected per-cycle waveform to a queue; capture()
//   pops it and compares the serial/active/done/ready traces sampled on the
//   falling clock edge over the whole frame plus the following cycle.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame;

  localparam int C = 4;

  typedef struct {
    int          sel;
    int          len;
    logic [63:0] ser;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] dv;
  logic [7:0] byte_a;
  logic [6:0] byte_b;
  logic [7:0] byte_c;
  logic [1:0] mode_a, mode_b, mode_c;
  logic [2:0] rdy, act, ser, done;

  int   vectors;
  int   miscompares;
  exp_t exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  uart_tx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(8), .STOP_BITS(1)) u_dut_8n1 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_TX_DV(dv[0]), .i_TX_Byte(byte_a),
    .i_Parity_Mode(mode_a), .o_TX_Ready(rdy[0]), .o_TX_Active(act[0]),
    .o_TX_Serial(ser[0]), .o_TX_Done(done[0]));

  uart_tx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(7), .STOP_BITS(1)) u_dut_7b (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_TX_DV(dv[1]), .i_TX_Byte(byte_b),
    .i_Parity_Mode(mode_b), .o_TX_Ready(rdy[1]), .o_TX_Active(act[1]),
    .o_TX_Serial(ser[1]), .o_TX_Done(done[1]));

  uart_tx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(8), .STOP_BITS(2)) u_dut_2s (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_TX_DV(dv[2]), .i_TX_Byte(byte_c),
    .i_Parity_Mode(mode_c), .o_TX_Ready(rdy[2]), .o_TX_Active(act[2]),
    .o_TX_Serial(ser[2]), .o_TX_Done(done[2]));

  function automatic int nb_of(input int sel);
    return (sel == 1) ? 7 : 8;
  endfunction

  function automatic int st_of(input int sel);
    return (sel == 2) ? 2 : 1;
  endfunction

  function automatic bit par_active(input logic [1:0] m);
`ifdef UART_TX_PARITY_EN
    return (m == 2'b01) || (m == 2'b10);
`else
    return 1'b0;
`endif
  endfunction

  // Reference frame: list of bit values, each stretched to C cycles, then
  // one mark cycle after the frame.
  function automatic exp_t model(input int sel, input logic [8:0] d, input logic [1:0] m);
    exp_t        e;
    logic [15:0] fb;
    int          n;
    int          ones;
    fb   = '0;
    n    = 0;
    ones = 0;
    fb[n] = 1'b0;
    n++;
    for (int i = 0; i < nb_of(sel); i++) begin
      fb[n] = d[i];
      ones += int'(d[i]);
      n++;
    end
    if (par_active(m)) begin
      fb[n] = (ones % 2 == 1) ? (m == 2'b01) : (m == 2'b10);
      n++;
    end
    for (int i = 0; i < st_of(sel); i++) begin
      fb[n] = 1'b1;
      n++;
    end
    e.sel = sel;
    e.len = n * C;
    e.ser = '0;
    for (int i = 0; i < e.len; i++) e.ser[i] = fb[i / C];
    e.ser[e.len] = 1'b1;
    return e;
  endfunction

  task automatic set_in(input int sel, input logic [8:0] d, input logic [1:0] m);
    case (sel)
      0:       begin byte_a = d[7:0]; mode_a = m; end
      1:       begin byte_b = d[6:0]; mode_b = m; end
      default: begin byte_c = d[7:0]; mode_c = m; end
    endcase
  endtask

  task automatic set_dv(input int sel, input logic v);
    dv[sel] = v;
  endtask

  // Present a byte on a falling edge, record its expected frame, and return
  // just after the accepting rising edge.
  task automatic send(input int sel, input logic [8:0] d, input logic [1:0] m, input bit hold);
    @(negedge clk);
    set_in(sel, d, m);
    set_dv(sel, 1'b1);
    exp_q.push_back(model(sel, d, m));
    @(posedge clk);
    if (!hold) begin
      #1 set_dv(sel, 1'b0);
    end
  endtask

  // Pop the next expected frame and compare len+1 falling-edge samples.
  task automatic capture(input int sel, input string name);
    exp_t        e;
    logic [63:0] os, oa, od, orr, mask, ea, ed;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: no expected frame queued", name);
      return;
    end
    e = exp_q.pop_front();
    if (e.sel != sel) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: queued frame belongs to instance %0d not %0d", name, e.sel, sel);
    end
    os = '0; oa = '0; od = '0; orr = '0;
    for (int i = 0; i <= e.len; i++) begin
      @(negedge clk);
      os[i]  = ser[sel];
      oa[i]  = act[sel];
      od[i]  = done[sel];
      orr[i] = rdy[sel];
    end
    mask = (64'd1 << (e.len + 1)) - 64'd1;
    ea   = (64'd1 << e.len) - 64'd1;
    ed   = 64'd1 << e.len;
    vectors++;
    if ((os & mask) !== (e.ser & mask)) begin
      miscompares++;
      $display("FAIL %s serial: got %h expected %h", name, os & mask, e.ser & mask);
    end
    vectors++;
    if ((oa & mask) !== ea) begin
      miscompares++;
      $display("FAIL %s active: got %h expected %h", name, oa & mask, ea);
    end
    vectors++;
    if ((od & mask) !== ed) begin
      miscompares++;
      $display("FAIL %s done: got %h expected %h", name, od & mask, ed);
    end
    vectors++;
    if ((orr & mask) !== ed) begin
      miscompares++;
      $display("FAIL %s ready: got %h expected %h", name, orr & mask, ed);
    end
  endtask

  task automatic check_idle(input int sel, input string name);
    vectors++;
    if ({ser[sel], act[sel], done[sel], rdy[sel]} !== 4'b1001) begin
      miscompares++;
      $display("FAIL %s: got ser/act/done/rdy=%b expected 1001", name,
               {ser[sel], act[sel], done[sel], rdy[sel]});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dv    = '0;
    set_in(0, 9'h0, 2'b00);
    set_in(1, 9'h0, 2'b00);
    set_in(2, 9'h0, 2'b00);
    #12;
    for (int s = 0; s < 3; s++) check_idle(s, "reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) check_idle(s, "post_reset_idle");
  endtask

  task automatic test_8n1();
    send(0, 9'h0A5, 2'b00, 1'b0);
    capture(0, "8n1_a5");
    send(0, 9'h000, 2'b00, 1'b0);
    capture(0, "8n1_00");
    send(0, 9'h0FF, 2'b11, 1'b0);
    capture(0, "8n1_ff_mode11");
  endtask

  task automatic test_parity();
    send(1, 9'h041, 2'b10, 1'b0);
    capture(1, "7b_odd_41");
    send(1, 9'h041, 2'b01, 1'b0);
    capture(1, "7b_even_41");
    send(1, 9'h013, 2'b10, 1'b0);
    capture(1, "7b_odd_13");
  endtask

  task automatic test_mode_no_parity();
    send(0, 9'h05A, 2'b01, 1'b0);
    capture(0, "8b_mode01_5a");
  endtask

  task automatic test_back_to_back();
    int first_len;
    @(negedge clk);
    set_in(2, 9'h055, 2'b00);
    set_dv(2, 1'b1);
    exp_q.push_back(model(2, 9'h055, 2'b00));
    first_len = exp_q[exp_q.size() - 1].len;
    fork
      begin
        capture(2, "b2b_55");
        capture(2, "b2b_aa");
      end
      begin
        @(posedge clk);
        #1 set_in(2, 9'h0AA, 2'b00);
        exp_q.push_back(model(2, 9'h0AA, 2'b00));
        repeat (first_len + 1) @(posedge clk);
        #1 set_dv(2, 1'b0);
      end
    join
  endtask

  task automatic test_busy_ignored();
    logic [15:0] trail;
    send(0, 9'h096, 2'b00, 1'b0);
    fork
      capture(0, "busy_96");
      begin
        repeat (12) @(posedge clk);
        #1 set_in(0, 9'h0FF, 2'b00);
        set_dv(0, 1'b1);
        @(posedge clk);
        #1 set_dv(0, 1'b0);
      end
    join
    trail = '0;
    for (int i = 0; i < 3 * C; i++) begin
      @(negedge clk);
      trail[i] = act[0] | ~ser[0];
    end
    vectors++;
    if (trail !== 16'h0000) begin
      miscompares++;
      $display("FAIL busy_trailing_idle: got activity mask %h expected 0000", trail);
    end
  endtask

  task automatic test_reset_mid_frame();
    exp_t dropped;
    send(0, 9'h0C3, 2'b00, 1'b0);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    dropped = exp_q.pop_front();
    vectors++;
    if ({ser[0], act[0], done[0], rdy[0]} !== 4'b1001) begin
      miscompares++;
      $display("FAIL mid_reset: got ser/act/done/rdy=%b expected 1001 (frame len %0d)",
               {ser[0], act[0], done[0], rdy[0]}, dropped.len);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(0, 9'h03C, 2'b00, 1'b0);
    capture(0, "after_reset_3c");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_8n1();
    test_parity();
    test_mode_no_parity();
    test_back_to_back();
    test_busy_ignored();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
